// File: rtl/paddsub_serial.sv
// paddsub_serial: packed saturating add/sub engine. Two WIDTH-bit operands are
// accepted on a valid/ready handshake. Their nibbles are streamed LSB-first,
// one per cycle, through a single saturating addsub_4bit lane. The collected
// result and the per-nibble saturation flags are then offered on an output
// valid/ready handshake.

// addsub_4bit: one saturating signed add/sub lane (two's complement).
module addsub_4bit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_eff;
  logic [W-1:0] raw;
  logic         ovf;

  // Add a to b, or to ~b+1 for subtraction; clamp the result on signed overflow.
  always_comb begin
    b_eff = sub ? ~b : b;
    raw   = a + b_eff + {{(W-1){1'b0}}, sub};
    ovf   = (a[W-1] == b_eff[W-1]) && (raw[W-1] != a[W-1]);
    // On overflow both operands share a sign, so the sign of a gives the direction.
    if (ovf) sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else     sum = raw;
  end

endmodule

module paddsub_serial #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic [(WIDTH/LANE)-1:0]  sat_flags
);

  localparam int NLANE = WIDTH / LANE;
  localparam int IDX_W = (NLANE > 1) ? $clog2(NLANE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [NLANE-1:0]   sat_q, sat_d;

  logic [LANE-1:0]    lane_a;
  logic [LANE-1:0]    lane_b;
  logic [LANE-1:0]    lane_sum;
  logic [LANE-1:0]    ovf_b_eff;
  logic [LANE-1:0]    ovf_raw;
  logic               lane_ovf;

  // Select the current nibble from the latched operands, and derive its overflow flag.
  always_comb begin
    lane_a    = a_q[int'(idx_q)*LANE +: LANE];
    lane_b    = b_q[int'(idx_q)*LANE +: LANE];
    ovf_b_eff = sub_q ? ~lane_b : lane_b;
    ovf_raw   = lane_a + ovf_b_eff + {{(LANE-1){1'b0}}, sub_q};
    lane_ovf  = (lane_a[LANE-1] == ovf_b_eff[LANE-1]) &&
                (ovf_raw[LANE-1] != lane_a[LANE-1]);
  end

  addsub_4bit #(.W(LANE)) u_lane (
    .a   (lane_a),
    .b   (lane_b),
    .sub (sub_q),
    .sum (lane_sum)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    result_d  = result_q;
    sat_d     = sat_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          sub_d    = sub;
          result_d = '0;
          sat_d    = '0;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[int'(idx_q)*LANE +: LANE] = lane_sum;
        sat_d[idx_q]                       = lane_ovf;
        if (idx_q == IDX_W'(NLANE - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      sat_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign result    = result_q;
  assign sat_flags = sat_q;

endmodule

// File: tb/tb_paddsub_serial.sv
// tb_paddsub_serial: directed test of paddsub_serial. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_paddsub_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  sat_flags;

  int checks;
  int errors;

  paddsub_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat_flags (sat_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands, accept them at the next edge and scramble the inputs.
  // Then verify that out_valid rises exactly 4 edges after the accept edge
  // with the expected result. The output handshake is not completed here.
  task automatic issue_and_wait(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic s, input logic [15:0] exp_r, input logic [3:0] exp_f);
    A = a; B = b; sub = s; in_valid = 1'b1;
    step();                                   // accept edge E0
    in_valid = 1'b0; A = ~a; B = ~b; sub = ~s;
    check({tag, " in_ready after accept"}, {15'd0, in_ready}, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check({tag, " out_valid early"}, {15'd0, out_valid}, 16'd0);
    end
    step();                                   // E4
    check({tag, " out_valid at E4"}, {15'd0, out_valid}, 16'd1);
    check({tag, " result"}, result, exp_r);
    check({tag, " sat_flags"}, {12'd0, sat_flags}, {12'd0, exp_f});
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " out_valid after drain"}, {15'd0, out_valid}, 16'd0);
    check({tag, " in_ready after drain"}, {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0; B = 16'h0; sub = 1'b0;

    // Reset state.
    #12;
    check("reset in_ready", {15'd0, in_ready}, 16'd1);
    check("reset out_valid", {15'd0, out_valid}, 16'd0);
    check("reset result", result, 16'h0000);
    check("reset sat_flags", {12'd0, sat_flags}, 16'd0);
    rst_n = 1'b1;
    step();

    // Plain add, no saturation.
    issue_and_wait("t1", 16'h1234, 16'h1111, 1'b0, 16'h2345, 4'b0000);
    drain("t1");

    // Positive saturation in every nibble.
    issue_and_wait("t2", 16'h7777, 16'h1111, 1'b0, 16'h7777, 4'b1111);
    drain("t2");

    // Subtract: nibble1 is -8-1, which saturates to 0x8.
    issue_and_wait("t3", 16'h7080, 16'h1010, 1'b1, 16'h6080, 4'b0010);
    drain("t3");

    // Nibbles: -8+1=-7 (0x9), -1+-8 saturates to 0x8, and so on.
    issue_and_wait("t4", 16'hF8F8, 16'h8181, 1'b0, 16'h8989, 4'b1010);
    // Hold DONE while a new request is presented.
    A = 16'h0123; B = 16'h0101; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4 hold out_valid", {15'd0, out_valid}, 16'd1);
      check("t4 hold in_ready", {15'd0, in_ready}, 16'd0);
      check("t4 hold result", result, 16'h8989);
      check("t4 hold sat_flags", {12'd0, sat_flags}, 16'h000A);
    end
    // out_ready and in_valid are high together: only the output handshake completes.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4 simul in_ready", {15'd0, in_ready}, 16'd1);
    check("t4 simul out_valid", {15'd0, out_valid}, 16'd0);
    check("t4 simul result kept", result, 16'h8989);
    // The pending request is accepted from IDLE and uses its own operands.
    issue_and_wait("t4b", 16'h0123, 16'h0101, 1'b1, 16'h0022, 4'b0000);
    drain("t4b");

    // Reset abandons an operation after 2 RUN edges.
    A = 16'h1234; B = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("t5 partial result", result, 16'h0045);
    #1 rst_n = 1'b0;
    #1;
    check("t5 async in_ready", {15'd0, in_ready}, 16'd1);
    check("t5 async out_valid", {15'd0, out_valid}, 16'd0);
    check("t5 async result", result, 16'h0000);
    check("t5 async sat_flags", {12'd0, sat_flags}, 16'd0);
    #2 rst_n = 1'b1;
    step();
    check("t5 no out_valid", {15'd0, out_valid}, 16'd0);
    issue_and_wait("t5b", 16'h7777, 16'h1111, 1'b0, 16'h7777, 4'b1111);
    drain("t5b");

    // Back-to-back: out_ready and in_valid stay high, giving one accept every 6 cycles.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    begin
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic        vs [3];
      logic [15:0] vr [3];
      logic [3:0]  vf [3];
      va[0] = 16'h0000; vb[0] = 16'h8888; vs[0] = 1'b1; vr[0] = 16'h7777; vf[0] = 4'b1111;
      va[1] = 16'h8888; vb[1] = 16'h0000; vs[1] = 1'b1; vr[1] = 16'h8888; vf[1] = 4'b0000;
      va[2] = 16'h1234; vb[2] = 16'h1111; vs[2] = 1'b0; vr[2] = 16'h2345; vf[2] = 4'b0000;
      for (int k = 0; k < 3; k++) begin
        A = va[k]; B = vb[k]; sub = vs[k];
        check("t6 in_ready before accept", {15'd0, in_ready}, 16'd1);
        step();                               // accept edge
        check("t6 in_ready after accept", {15'd0, in_ready}, 16'd0);
        A = 16'hFFFF; B = 16'hFFFF; sub = ~vs[k];
        for (int i = 1; i <= 3; i++) begin
          step();
          check("t6 out_valid early", {15'd0, out_valid}, 16'd0);
        end
        step();                               // E4
        check("t6 out_valid", {15'd0, out_valid}, 16'd1);
        check("t6 result", result, vr[k]);
        check("t6 sat_flags", {12'd0, sat_flags}, {12'd0, vf[k]});
        step();                               // E5: output handshake, back to IDLE
        check("t6 out_valid after handshake", {15'd0, out_valid}, 16'd0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
